// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - state, opcode and select encodings for the LEGv8 multi-cycle control
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_LD_WB    = 4'd6,
    ST_EXEC_R   = 4'd7,
    ST_R_WB     = 4'd8,
    ST_CBZ_EX   = 4'd9,
    ST_B_EX     = 4'd10,
    ST_HALT     = 4'd11
  } state_e;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  // CBZ and B carry immediate bits in the low opcode field, so only the prefix is fixed
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_PASSB = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_DIMM = 2'b10,
    SRCB_BR   = 2'b11
  } srcb_e;

  typedef struct packed {
    logic mem_ld;
    logic mem_st;
    logic rtype;
    logic cbz;
    logic b;
    logic illegal;
  } op_class_t;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// rtl/legv8_multicycle_ctrl_if.sv - datapath status and control bundle of the LEGv8 control FSM
interface legv8_multicycle_ctrl_if;

  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;

  logic [1:0]  ALUop;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemtoReg;
  logic        Reg2Loc;
  logic        PCSource;
  logic        Halted;
  logic [3:0]  State;

  modport master (
    input  Opcode, Zero, MemReady,
    output ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           PCWrite, RegWrite, MemtoReg, Reg2Loc, PCSource, Halted, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           PCWrite, RegWrite, MemtoReg, Reg2Loc, PCSource, Halted, State
  );

endinterface

// File: rtl/legv8_multicycle_ctrl_opcode_class.sv
// rtl/legv8_multicycle_ctrl_opcode_class.sv - one-hot instruction class decode of the 11-bit opcode
module legv8_opcode_class
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  output op_class_t   class_o
);

  always_comb begin
    class_o = '0;
    if (opcode_i == OP_LDUR) begin
      class_o.mem_ld = 1'b1;
    end else if (opcode_i == OP_STUR) begin
      class_o.mem_st = 1'b1;
    end else if (is_rtype(opcode_i)) begin
      class_o.rtype = 1'b1;
    end else if (opcode_i[10:3] == OP_CBZ_PFX) begin
      class_o.cbz = 1'b1;
    end else if (opcode_i[10:5] == OP_B_PFX) begin
      class_o.b = 1'b1;
    end else begin
      class_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - Moore main control FSM sequencing the multi-cycle LEGv8 datapath
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
(
  input  logic                      CLK,
  input  logic                      ResetL,
  legv8_multicycle_ctrl_if.master   ctrl
);

  state_e    state_q, state_d;
  logic      start_q;
  op_class_t op_class;

  legv8_opcode_class u_opcode_class (
    .opcode_i (ctrl.Opcode),
    .class_o  (op_class)
  );

  // start_q holds IDLE for one extra edge after reset release so FETCH begins on the second edge
  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= 1'b1;
    end
  end

  assign ctrl.State = state_q;

  always_comb begin
    state_d       = state_q;
    ctrl.ALUop    = ALUOP_ADD;
    ctrl.ALUSrcA  = 1'b0;
    ctrl.ALUSrcB  = SRCB_REG;
    ctrl.IorD     = 1'b0;
    ctrl.MemRead  = 1'b0;
    ctrl.MemWrite = 1'b0;
    ctrl.IRWrite  = 1'b0;
    ctrl.PCWrite  = 1'b0;
    ctrl.RegWrite = 1'b0;
    ctrl.MemtoReg = 1'b0;
    ctrl.Reg2Loc  = 1'b0;
    ctrl.PCSource = 1'b0;
    ctrl.Halted   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_q) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        ctrl.MemRead = 1'b1;
        ctrl.ALUSrcB = SRCB_FOUR;
        ctrl.IRWrite = ctrl.MemReady;
        ctrl.PCWrite = ctrl.MemReady;
        if (ctrl.MemReady) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        ctrl.ALUSrcB = SRCB_BR;
        ctrl.Reg2Loc = op_class.mem_st | op_class.cbz;
        if (op_class.illegal)                      state_d = ST_HALT;
        else if (op_class.mem_ld | op_class.mem_st) state_d = ST_MEM_ADDR;
        else if (op_class.rtype)                   state_d = ST_EXEC_R;
        else if (op_class.cbz)                     state_d = ST_CBZ_EX;
        else                                       state_d = ST_B_EX;
      end

      ST_MEM_ADDR: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = SRCB_DIMM;
        ctrl.Reg2Loc = op_class.mem_st;
        if (op_class.mem_ld)      state_d = ST_MEM_RD;
        else if (op_class.mem_st) state_d = ST_MEM_WR;
        else                      state_d = ST_HALT;
      end

      ST_MEM_RD: begin
        ctrl.MemRead = 1'b1;
        ctrl.IorD    = 1'b1;
        if (ctrl.MemReady) state_d = ST_LD_WB;
      end

      ST_MEM_WR: begin
        ctrl.MemWrite = 1'b1;
        ctrl.IorD     = 1'b1;
        ctrl.Reg2Loc  = 1'b1;
        if (ctrl.MemReady) state_d = ST_FETCH;
      end

      ST_LD_WB: begin
        ctrl.RegWrite = 1'b1;
        ctrl.MemtoReg = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_EXEC_R: begin
        ctrl.ALUSrcA = 1'b1;
        ctrl.ALUSrcB = SRCB_REG;
        ctrl.ALUop   = ALUOP_RTYPE;
        state_d      = ST_R_WB;
      end

      ST_R_WB: begin
        ctrl.RegWrite = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_CBZ_EX: begin
        ctrl.Reg2Loc  = 1'b1;
        ctrl.ALUSrcA  = 1'b1;
        ctrl.ALUSrcB  = SRCB_REG;
        ctrl.ALUop    = ALUOP_PASSB;
        ctrl.PCSource = 1'b1;
        ctrl.PCWrite  = ctrl.Zero;
        state_d       = ST_FETCH;
      end

      ST_B_EX: begin
        ctrl.PCWrite  = 1'b1;
        ctrl.PCSource = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_HALT: begin
        ctrl.Halted = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb/tb_legv8_multicycle_ctrl.sv - randomized instruction-level bench for the LEGv8 control FSM
module tb_legv8_multicycle_ctrl;
  import legv8_ctrl_pkg::*;

  logic CLK    = 1'b0;
  logic ResetL = 1'b0;
  always #5 CLK = ~CLK;

  legv8_multicycle_ctrl_if bus ();

  legv8_multicycle_ctrl dut (
    .CLK    (CLK),
    .ResetL (ResetL),
    .ctrl   (bus)
  );

  typedef struct packed {
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       m2r;
    logic       r2l;
    logic       pcs;
    logic       halt;
  } ctrl_t;

  typedef struct {
    state_e      st;
    ctrl_t       c;
    logic [10:0] op;
    logic        rdy;
    logic        z;
  } cyc_t;

  typedef enum {K_LD, K_ST, K_R, K_CBZ, K_B, K_ILL} kind_e;

  cyc_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t observe();
    ctrl_t c;
    c.aluop = bus.ALUop;    c.srca = bus.ALUSrcA;  c.srcb = bus.ALUSrcB;
    c.iord  = bus.IorD;     c.mr   = bus.MemRead;  c.mw   = bus.MemWrite;
    c.irw   = bus.IRWrite;  c.pcw  = bus.PCWrite;  c.rw   = bus.RegWrite;
    c.m2r   = bus.MemtoReg; c.r2l  = bus.Reg2Loc;  c.pcs  = bus.PCSource;
    c.halt  = bus.Halted;
    return c;
  endfunction

  task automatic push(input state_e st, input ctrl_t c, input logic [10:0] op,
                      input logic rdy, input logic z);
    cyc_t r;
    r.st = st; r.c = c; r.op = op; r.rdy = rdy; r.z = z;
    q.push_back(r);
  endtask

  function automatic logic is_legal(input logic [10:0] op);
    return op == 11'b11111000010 || op == 11'b11111000000 ||
           op == 11'b10001011000 || op == 11'b11001011000 ||
           op == 11'b10001010000 || op == 11'b10101010000 ||
           op[10:3] == 8'b10110100 || op[10:5] == 6'b000101;
  endfunction

  function automatic logic [10:0] pick_op(input kind_e k);
    logic [10:0] op;
    case (k)
      K_LD:  op = 11'b11111000010;
      K_ST:  op = 11'b11111000000;
      K_R: begin
        case ($urandom_range(0, 3))
          0:       op = 11'b10001011000;
          1:       op = 11'b11001011000;
          2:       op = 11'b10001010000;
          default: op = 11'b10101010000;
        endcase
      end
      K_CBZ: op = {8'b10110100, 3'($urandom)};
      K_B:   op = {6'b000101, 5'($urandom)};
      default: begin
        op = 11'($urandom);
        while (is_legal(op)) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  // Expands one instruction into the cycle-by-cycle outputs the control must show
  task automatic gen_instr(input kind_e k, input logic [10:0] op, input int fw,
                           input int mw, input logic z, input int halt_cycles);
    ctrl_t c;
    for (int i = 0; i <= fw; i++) begin
      c = '0; c.mr = 1'b1; c.srcb = 2'b01;
      c.irw = (i == fw); c.pcw = (i == fw);
      push(ST_FETCH, c, 11'($urandom), i == fw, 1'($urandom));
    end
    c = '0; c.srcb = 2'b11; c.r2l = (k == K_ST) || (k == K_CBZ);
    push(ST_DECODE, c, op, 1'($urandom), 1'($urandom));
    case (k)
      K_LD, K_ST: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.r2l = (k == K_ST);
        push(ST_MEM_ADDR, c, op, 1'($urandom), 1'($urandom));
        for (int i = 0; i <= mw; i++) begin
          c = '0; c.iord = 1'b1;
          if (k == K_LD) c.mr = 1'b1;
          else begin c.mw = 1'b1; c.r2l = 1'b1; end
          push(k == K_LD ? ST_MEM_RD : ST_MEM_WR, c, op, i == mw, 1'($urandom));
        end
        if (k == K_LD) begin
          c = '0; c.rw = 1'b1; c.m2r = 1'b1;
          push(ST_LD_WB, c, op, 1'($urandom), 1'($urandom));
        end
      end
      K_R: begin
        c = '0; c.srca = 1'b1; c.srcb = 2'b00; c.aluop = 2'b10;
        push(ST_EXEC_R, c, op, 1'($urandom), 1'($urandom));
        c = '0; c.rw = 1'b1;
        push(ST_R_WB, c, op, 1'($urandom), 1'($urandom));
      end
      K_CBZ: begin
        c = '0; c.r2l = 1'b1; c.srca = 1'b1; c.aluop = 2'b01; c.pcs = 1'b1; c.pcw = z;
        push(ST_CBZ_EX, c, op, 1'($urandom), z);
      end
      K_B: begin
        c = '0; c.pcw = 1'b1; c.pcs = 1'b1;
        push(ST_B_EX, c, op, 1'($urandom), 1'($urandom));
      end
      default: begin
        for (int i = 0; i < halt_cycles; i++) begin
          c = '0; c.halt = 1'b1;
          push(ST_HALT, c, 11'($urandom), 1'($urandom), 1'($urandom));
        end
      end
    endcase
  endtask

  task automatic drain(input int n);
    cyc_t r;
    int   cnt = 0;
    while (q.size() > 0 && (n < 0 || cnt < n)) begin
      r = q.pop_front();
      cnt++;
      @(negedge CLK);
      bus.Opcode = r.op; bus.MemReady = r.rdy; bus.Zero = r.z;
      #1;
      check($sformatf("%s state", r.st.name()), 32'(bus.State), 32'(r.st));
      check($sformatf("%s ctrl", r.st.name()), 32'(observe()), 32'(r.c));
    end
  endtask

  task automatic do_reset(input string tag);
    ctrl_t c;
    #1 ResetL = 1'b0;
    #1;
    check({tag, " state"}, 32'(bus.State), 32'(ST_IDLE));
    check({tag, " ctrl"}, 32'(observe()), 32'h0);
    check({tag, " memwrite"}, 32'(bus.MemWrite), 32'h0);
    repeat (2) @(posedge CLK);
    #2 ResetL = 1'b1;
    c = '0;
    repeat (2) push(ST_IDLE, c, 11'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    kind_e k;
    bus.Opcode   = '0;
    bus.MemReady = 1'b0;
    bus.Zero     = 1'b0;
    do_reset("por");

    gen_instr(K_R,   11'b10001011000, 0, 0, 1'b0, 0);
    gen_instr(K_LD,  11'b11111000010, 0, 2, 1'b0, 0);
    gen_instr(K_CBZ, pick_op(K_CBZ),  0, 0, 1'b1, 0);
    gen_instr(K_CBZ, pick_op(K_CBZ),  0, 0, 1'b0, 0);
    gen_instr(K_ST,  11'b11111000000, 0, 0, 1'b0, 0);
    gen_instr(K_B,   pick_op(K_B),    1, 0, 1'b0, 0);
    drain(-1);

    for (int i = 0; i < 60; i++) begin
      k = kind_e'($urandom_range(0, 4));
      gen_instr(k, pick_op(k), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 0);
    end
    drain(-1);

    // STUR stalled in MEM_WR: reset lands on the third wait cycle
    gen_instr(K_ST, 11'b11111000000, 1, 5, 1'b0, 0);
    drain(7);
    q.delete();
    do_reset("memwr_reset");
    gen_instr(K_R, pick_op(K_R), 0, 0, 1'b0, 0);
    drain(-1);

    q.delete();
    gen_instr(K_ILL, 11'b11111111111, 0, 0, 1'b0, 20);
    drain(-1);
    do_reset("halt_reset");
    gen_instr(K_ILL, pick_op(K_ILL), 1, 0, 1'b0, 5);
    drain(-1);
    do_reset("halt_reset2");
    gen_instr(K_LD, 11'b11111000010, 2, 1, 1'b0, 0);
    drain(-1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Moore-style main control FSM for the multi-cycle LEGv8 core. It sequences one shared ALU, the register file and a single unified instruction/data memory with wait states. It decodes the 11-bit opcode held in the external instruction register and drives `ALUop` into the existing ALU control block, together with the mux selects and write enables for each phase of the instruction. Supported instructions: LDUR, STUR, ADD, SUB, AND, ORR, CBZ, B; any other opcode halts the core.

## Interface
- No parameters. Opcode and state constants come from `legv8_ctrl_pkg`.
- `CLK` in 1 — single clock; all state updates on the rising edge.
- `ResetL` in 1 — asynchronous, active-low reset.
- `Opcode` in 11 — IR[31:21]; stable from the cycle after the fetch completes.
- `Zero` in 1 — ALU zero flag, combinational from the current ALU operation.
- `MemReady` in 1 — memory completes the current access this cycle.
- `ALUop` out 2 — 00 add, 01 pass B / CBZ, 10 R-type (function taken from `Opcode`).
- `ALUSrcA` out 1 — 0 = PC, 1 = register A.
- `ALUSrcB` out 2 — 00 = register B, 01 = constant 4, 10 = sign-extended D-immediate, 11 = shifted branch offset.
- `IorD` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`, `MemtoReg`, `Reg2Loc` out 1 each.
- `PCSource` out 1 — 0 = ALU result, 1 = ALUOut register.
- `Halted` out 1 — sticky illegal-opcode flag.
- `State` out 4 — current state encoding, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WR, LD_WB, EXEC_R, R_WB, CBZ_EX, B_EX, HALT.
- IDLE: all outputs 0; the next state is always FETCH.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUop`=00, `PCSource`=0.
  - `IRWrite` and `PCWrite` equal `MemReady`.
  - Stay in FETCH while `MemReady`=0; go to DECODE when it is 1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUop`=00 (branch target into ALUOut).
  - `Reg2Loc`=1 when the opcode is STUR or CBZ.
  - Next state: LDUR/STUR → MEM_ADDR; R-type → EXEC_R; CBZ → CBZ_EX; B → B_EX; anything else → HALT.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUop`=00, `Reg2Loc` held as in DECODE.
  - Next state: LDUR → MEM_RD; STUR → MEM_WR.
- MEM_RD: `MemRead`=1, `IorD`=1. Hold until `MemReady`, then go to LD_WB.
- MEM_WR: `MemWrite`=1, `IorD`=1, `Reg2Loc`=1. Hold until `MemReady`, then go to FETCH.
- LD_WB: `RegWrite`=1, `MemtoReg`=1, then go to FETCH.
- EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=10, then go to R_WB.
- R_WB: `RegWrite`=1, `MemtoReg`=0, then go to FETCH.
- CBZ_EX: `Reg2Loc`=1, `ALUSrcA`=1, `ALUSrcB`=00, `ALUop`=01, `PCSource`=1, `PCWrite`=`Zero`, then go to FETCH.
- B_EX: `PCWrite`=1, `PCSource`=1, then go to FETCH.
- HALT: all enables 0, `Halted`=1. Only reset leaves HALT.
- Any output not listed for a state is 0.

## Timing
- While `ResetL`=0: state is IDLE, all outputs 0, `Halted`=0.
- After `ResetL` rises, the first FETCH begins on the second rising edge.
- Cycles per instruction with `MemReady` held at 1:
  - R-type: 4.
  - LDUR: 5.
  - STUR: 4.
  - CBZ: 3.
  - B: 3.
- Each memory wait cycle adds exactly one cycle to the state that is waiting.
- `Zero` and `MemReady` are sampled combinationally. `PCWrite` and `IRWrite` may therefore change within a cycle; every other output depends on state only.
- Reset asserted mid-instruction, including during a memory wait: the FSM goes to IDLE immediately and all write enables drop asynchronously. No partial register write is allowed.
- `Opcode` is decoded only in DECODE, MEM_ADDR and the states after them. It is ignored in FETCH.

## Structure
- `legv8_ctrl_pkg` holds:
  - the state enum (4-bit);
  - the opcode constants LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ 10110100xxx, B 000101xxxxx;
  - the `ALUop` and `ALUSrcB` encodings.
- Sub-module `legv8_opcode_class`: combinational; maps `Opcode` to a one-hot class (MEM_LD, MEM_ST, RTYPE, CBZ, B, ILLEGAL). CBZ and B match on their prefix bits.

## Test plan
- ADD with `MemReady`=1 → states IDLE, FETCH, DECODE, EXEC_R, R_WB, FETCH; `ALUop`=10 in EXEC_R; `RegWrite`=1 for exactly 1 cycle.
- LDUR with `MemReady` low for 2 cycles in MEM_RD → MEM_RD lasts 3 cycles; `MemRead`=`IorD`=1 throughout; then LD_WB with `MemtoReg`=1; 7 cycles total.
- CBZ with `Zero`=1, then CBZ with `Zero`=0 → `PCWrite`=1 in CBZ_EX with `PCSource`=1 in the first case, 0 in the second; `ALUop`=01 in both.
- STUR → `Reg2Loc`=1 in DECODE, MEM_ADDR and MEM_WR; `MemWrite` pulses once; `RegWrite` never asserts.
- Opcode 11111111111 → DECODE then HALT; `Halted`=1 and every enable stays 0 for 20 cycles.
- `ResetL` pulled low during the MEM_WR wait → `MemWrite` drops the same cycle and `State`=IDLE; after release, FETCH starts on the second edge.
